// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of a PWM input, recovers duty code.
// Optional glitch filter on the synced input: define PWM_CAP_GLITCH_FILTER_EN.
module pwm_capture #(
   parameter int CNT_W    = 8,
   parameter int DUTY_W   = 3,
   parameter int TIMEOUT  = 255,
   parameter int FILT_LEN = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pwm_in,
   output logic [DUTY_W-1:0] duty,
   output logic [CNT_W-1:0]  high_cnt,
   output logic [CNT_W-1:0]  period_cnt,
   output logic              valid,
   output logic              stuck_hi,
   output logic              stuck_lo,
   output logic              overrun
);
   localparam int DC_W = $clog2(DUTY_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
   localparam logic [DC_W-1:0] DC_LAST = DC_W'(DUTY_W - 1);
   localparam logic [DC_W-1:0] DC_DONE = DC_W'(DUTY_W);

   typedef enum logic [1:0] {SEEK, MEAS, DIV} state_t;

   state_t state, state_nxt;

   logic sync1, sync2, lvl, lvl_d, rise;
   logic [CNT_W-1:0] per_ctr, hi_ctr;
   logic [CNT_W-1:0] snap_hi, snap_per, rem;
   logic [DUTY_W-1:0] quo, quo_nxt;
   logic [DUTY_W:0] quo_ext;
   logic [DC_W-1:0] div_cnt;
   logic clamp;
   logic [CNT_W:0] shl, dif;
   logic ge;
   logic cap, restart, tmo, ovr_set, clr_stuck, step, fin;
   logic stuck, per_to;
   logic unused_msb;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= pwm_in;
         sync2 <= sync1;
      end
   end

`ifdef PWM_CAP_GLITCH_FILTER_EN
   localparam int FC_W = $clog2(FILT_LEN + 1);
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_LEN - 1);

   logic [FC_W-1:0] filt_cnt;
   logic filt;

   // accepted level follows sync2 only after FILT_LEN differing samples in a row
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         filt     <= 1'b0;
         filt_cnt <= '0;
      end else if (sync2 == filt) begin
         filt_cnt <= '0;
      end else if (filt_cnt >= FC_LAST) begin
         filt     <= sync2;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + FC_W'(1);
      end
   end

   assign lvl = filt;
`else
   logic unused_filt;
   assign unused_filt = ^FILT_LEN;
   assign lvl = sync2;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lvl_d <= 1'b0;
      else      lvl_d <= lvl;
   end

   assign rise   = lvl & ~lvl_d;
   assign stuck  = stuck_hi | stuck_lo;
   assign per_to = (per_ctr >= TMO);

   // restoring divider step: remainder stays below the snapped period
   always_comb begin
      shl     = {rem, 1'b0};
      dif     = shl - {1'b0, snap_per};
      ge      = (shl >= {1'b0, snap_per});
      quo_ext = {quo, ge};
      quo_nxt = quo_ext[DUTY_W-1:0];
   end

   assign unused_msb = dif[CNT_W] ^ quo_ext[DUTY_W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= SEEK;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cap       = 1'b0;
      restart   = 1'b0;
      tmo       = 1'b0;
      ovr_set   = 1'b0;
      clr_stuck = 1'b0;
      step      = (state == DIV) && (div_cnt != DC_DONE);
      fin       = step && (div_cnt == DC_LAST);
      unique case (state)
         SEEK: begin
            if (rise) begin
               restart   = 1'b1;
               clr_stuck = 1'b1;
               state_nxt = MEAS;
            end else if (!stuck && per_to) begin
               tmo = 1'b1;
            end
         end
         MEAS: begin
            if (rise) begin
               cap       = 1'b1;
               restart   = 1'b1;
               state_nxt = DIV;
            end else if (per_to) begin
               tmo       = 1'b1;
               state_nxt = SEEK;
            end
         end
         DIV: begin
            // divider keeps its older snapshot; the new capture is lost
            if (rise) begin
               restart = 1'b1;
               ovr_set = 1'b1;
            end
            if (div_cnt == DC_DONE) state_nxt = MEAS;
         end
         default: state_nxt = SEEK;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         per_ctr <= '0;
         hi_ctr  <= '0;
      end else if (restart) begin
         per_ctr <= CNT_ONE;
         hi_ctr  <= CNT_ONE;
      end else if (tmo) begin
         per_ctr <= '0;
         hi_ctr  <= '0;
      end else if (state != SEEK || !stuck) begin
         if (per_ctr != CNT_MAX)
            per_ctr <= per_ctr + CNT_ONE;
         if (lvl && state != SEEK && hi_ctr != CNT_MAX)
            hi_ctr <= hi_ctr + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snap_hi  <= '0;
         snap_per <= '0;
         rem      <= '0;
         quo      <= '0;
         div_cnt  <= '0;
         clamp    <= 1'b0;
      end else if (cap) begin
         snap_hi  <= hi_ctr;
         snap_per <= per_ctr;
         rem      <= hi_ctr;
         quo      <= '0;
         div_cnt  <= '0;
         clamp    <= (hi_ctr >= per_ctr);
      end else if (step) begin
         rem     <= ge ? dif[CNT_W-1:0] : shl[CNT_W-1:0];
         quo     <= quo_nxt;
         div_cnt <= div_cnt + DC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         duty       <= '0;
         high_cnt   <= '0;
         period_cnt <= '0;
         valid      <= 1'b0;
         stuck_hi   <= 1'b0;
         stuck_lo   <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         valid <= fin | tmo;
         if (fin) begin
            duty       <= clamp ? '1 : quo_nxt;
            high_cnt   <= snap_hi;
            period_cnt <= snap_per;
         end else if (tmo) begin
            duty       <= {DUTY_W{lvl}};
            high_cnt   <= '0;
            period_cnt <= '0;
         end
         if (tmo) begin
            stuck_hi <= lvl;
            stuck_lo <= ~lvl;
         end else if (clr_stuck) begin
            stuck_hi <= 1'b0;
            stuck_lo <= 1'b0;
         end
         if (ovr_set) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed-vector bench for pwm_capture (default parameters).
// Expected values are hand-computed for CNT_W=8, DUTY_W=3, TIMEOUT=255.
module tb_pwm_capture;

`ifdef PWM_CAP_GLITCH_FILTER_EN
   localparam int LAT = 8;
`else
   localparam int LAT = 6;
`endif

   logic       clk;
   logic       rst;
   logic       pwm_in;
   logic [2:0] duty;
   logic [7:0] high_cnt;
   logic [7:0] period_cnt;
   logic       valid;
   logic       stuck_hi;
   logic       stuck_lo;
   logic       overrun;

   int pass  = 0;
   int total = 0;
   int vcnt  = 0;

   pwm_capture dut (
      .clk        (clk),
      .rst        (rst),
      .pwm_in     (pwm_in),
      .duty       (duty),
      .high_cnt   (high_cnt),
      .period_cnt (period_cnt),
      .valid      (valid),
      .stuck_hi   (stuck_hi),
      .stuck_lo   (stuck_lo),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (valid === 1'b1) vcnt++;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic drive(input int hi, input int per, input int n);
      for (int k = 0; k < n; k++)
         for (int i = 0; i < per; i++) begin
            pwm_in = (i < hi);
            @(negedge clk);
         end
   endtask

   task automatic hold(input logic v, input int n);
      pwm_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({valid, stuck_hi, stuck_lo, overrun} !== 4'b0)
         $display("FAIL reset_flags got %b want 0000",
                  {valid, stuck_hi, stuck_lo, overrun});
      else pass++;
      total++;
      if (duty !== 3'd0 || high_cnt !== 8'd0 || period_cnt !== 8'd0)
         $display("FAIL reset_vals got %0d/%0d/%0d want 0/0/0",
                  duty, high_cnt, period_cnt);
      else pass++;
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic;
      int v0;
      v0 = vcnt;
      hold(1'b0, 4);
      drive(4, 8, 3);
      #2;
      total++;
      if (vcnt - v0 !== 2)
         $display("FAIL basic_valids got %0d want 2", vcnt - v0);
      else pass++;
      total++;
      if (duty !== 3'd4) $display("FAIL basic_duty got %0d want 4", duty);
      else pass++;
      total++;
      if (high_cnt !== 8'd4)
         $display("FAIL basic_high got %0d want 4", high_cnt);
      else pass++;
      total++;
      if (period_cnt !== 8'd8)
         $display("FAIL basic_period got %0d want 8", period_cnt);
      else pass++;
      total++;
      if (overrun !== 1'b0)
         $display("FAIL basic_overrun got %b want 0", overrun);
      else pass++;
   endtask

   task automatic test_latency;
      int lat;
      lat = -1;
      hold(1'b0, 12);
      for (int i = 0; i < 16; i++) begin
         pwm_in = (i < 4);
         @(negedge clk);
         if (valid === 1'b1 && lat < 0) lat = i + 1;
      end
      total++;
      if (lat !== LAT) $display("FAIL latency got %0d want %0d", lat, LAT);
      else pass++;
      total++;
      if (duty !== 3'd1 || high_cnt !== 8'd4 || period_cnt !== 8'd20)
         $display("FAIL lat_vals got %0d/%0d/%0d want 1/4/20",
                  duty, high_cnt, period_cnt);
      else pass++;
   endtask

   task automatic test_step;
      int hs [8] = '{4, 5, 6, 7, 6, 5, 4, 3};
      for (int s = 0; s < 8; s++) begin
         drive(hs[s], 8, 3);
         #2;
         total++;
         if (duty !== 3'(hs[s]) || high_cnt !== 8'(hs[s]) ||
             period_cnt !== 8'd8)
            $display("FAIL step_%0d got %0d/%0d/%0d want %0d/%0d/8",
                     s, duty, high_cnt, period_cnt, hs[s], hs[s]);
         else pass++;
      end
   endtask

   task automatic test_stuck_lo;
      int v0;
      int v1;
      v0 = vcnt;
      hold(1'b0, 240);
      total++;
      if (stuck_lo !== 1'b0)
         $display("FAIL stuck_lo_early got %b want 0", stuck_lo);
      else pass++;
      hold(1'b0, 60);
      #2;
      total++;
      if (stuck_lo !== 1'b1 || stuck_hi !== 1'b0 || duty !== 3'd0 ||
          high_cnt !== 8'd0 || period_cnt !== 8'd0)
         $display("FAIL stuck_lo_set got lo=%b hi=%b %0d/%0d/%0d want 1 0 0/0/0",
                  stuck_lo, stuck_hi, duty, high_cnt, period_cnt);
      else pass++;
      total++;
      if (vcnt - v0 !== 1)
         $display("FAIL stuck_lo_pulses got %0d want 1", vcnt - v0);
      else pass++;
      drive(4, 8, 1);
      #2;
      total++;
      if (stuck_lo !== 1'b0 || duty !== 3'd0)
         $display("FAIL stuck_lo_clear got lo=%b duty=%0d want 0 0",
                  stuck_lo, duty);
      else pass++;
      v1 = vcnt;
      drive(4, 8, 2);
      #2;
      total++;
      if (vcnt - v1 !== 2 || duty !== 3'd4)
         $display("FAIL stuck_lo_resume got v=%0d duty=%0d want 2 4",
                  vcnt - v1, duty);
      else pass++;
   endtask

   task automatic test_stuck_hi_reset;
      int v0;
      hold(1'b1, 300);
      #2;
      total++;
      if (stuck_hi !== 1'b1 || stuck_lo !== 1'b0 || duty !== 3'd7 ||
          high_cnt !== 8'd0 || period_cnt !== 8'd0)
         $display("FAIL stuck_hi_set got hi=%b lo=%b %0d/%0d/%0d want 1 0 7/0/0",
                  stuck_hi, stuck_lo, duty, high_cnt, period_cnt);
      else pass++;
      drive(4, 8, 2);
      hold(1'b1, 3);
      rst = 1'b0;
      #1;
      total++;
      if ({valid, stuck_hi, stuck_lo, overrun} !== 4'b0 || duty !== 3'd0 ||
          high_cnt !== 8'd0 || period_cnt !== 8'd0)
         $display("FAIL midreset got %b %0d/%0d/%0d want 0000 0/0/0",
                  {valid, stuck_hi, stuck_lo, overrun},
                  duty, high_cnt, period_cnt);
      else pass++;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      v0 = vcnt;
      drive(4, 8, 1);
      #2;
      total++;
      if (vcnt !== v0)
         $display("FAIL midreset_novalid got %0d want 0", vcnt - v0);
      else pass++;
      drive(4, 8, 2);
      #2;
      total++;
      if (vcnt - v0 !== 2 || duty !== 3'd4)
         $display("FAIL midreset_resume got v=%0d duty=%0d want 2 4",
                  vcnt - v0, duty);
      else pass++;
   endtask

   task automatic test_overrun;
      total++;
      if (overrun !== 1'b0)
         $display("FAIL ovr_clear got %b want 0", overrun);
      else pass++;
      drive(2, 4, 10);
      #2;
      total++;
      if (overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", overrun);
      else pass++;
      drive(2, 16, 4);
      #2;
      total++;
      if (overrun !== 1'b1 || duty !== 3'd1 || high_cnt !== 8'd2 ||
          period_cnt !== 8'd16)
         $display("FAIL ovr_sticky got o=%b %0d/%0d/%0d want 1 1/2/16",
                  overrun, duty, high_cnt, period_cnt);
      else pass++;
   endtask

   task automatic test_glitch;
      for (int k = 0; k < 4; k++)
         for (int i = 0; i < 8; i++) begin
            pwm_in = (i < 4) || (i == 5);
            @(negedge clk);
         end
      hold(1'b0, 10);
      #2;
      total++;
`ifdef PWM_CAP_GLITCH_FILTER_EN
      if (duty !== 3'd4 || high_cnt !== 8'd4 || period_cnt !== 8'd8)
         $display("FAIL glitch_filtered got %0d/%0d/%0d want 4/4/8",
                  duty, high_cnt, period_cnt);
      else pass++;
`else
      if (duty !== 3'd6 || high_cnt !== 8'd4 || period_cnt !== 8'd5)
         $display("FAIL glitch_raw got %0d/%0d/%0d want 6/4/5",
                  duty, high_cnt, period_cnt);
      else pass++;
`endif
   endtask

   initial begin
      rst = 1'b0;
      pwm_in = 1'b0;
      test_reset();
      test_basic();
      test_latency();
      test_step();
      test_stuck_lo();
      test_stuck_hi_reset();
      test_overrun();
      test_glitch();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
